// File: rtl/clint_mh_pkg.sv
// -----------------------------------------------------------------------------
// clint_mh_pkg
// Shared definitions for the multi-hart CLINT: access FSM states, register
// offsets within the 48 KiB window, and a byte-lane merge helper used by every
// writable register.
// -----------------------------------------------------------------------------
package clint_mh_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_LO_OFF = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF = 16'hBFFC;
  localparam logic [31:0] WINDOW_SIZE  = 32'h0000_C000;

  // Replace the bytes of old_val whose enable bit is set with those of new_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] result;
    for (int b = 0; b < 4; b++) begin
      result[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/clint_mh_if.sv
// -----------------------------------------------------------------------------
// clint_mh_if
// CPU data-port bus as seen by the CLINT. memReady follows the memory
// controller convention: 1 = idle/complete, 0 = access in progress.
//   addr, wdata, ren, wen, byte_select : CPU -> CLINT
//   rdata, memReady                    : CLINT -> CPU
// -----------------------------------------------------------------------------
interface clint_mh_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ren;
  logic        wen;
  logic [3:0]  byte_select;
  logic [31:0] rdata;
  logic        memReady;

  modport master (output addr, wdata, ren, wen, byte_select,
                  input  rdata, memReady);
  modport slave  (input  addr, wdata, ren, wen, byte_select,
                  output rdata, memReady);
endinterface

// File: rtl/clint_mh_timer.sv
// -----------------------------------------------------------------------------
// clint_mh_timer
// 64-bit mtime counter with a PRESCALE-clock prescaler and debug freeze.
//   clk, reset        : clock, asynchronous active-low reset
//   i_halt            : freeze mtime and prescaler while 1
//   i_wr_lo / i_wr_hi : commit a CPU write to the low / high word
//   i_wdata, i_be     : write data and byte-lane enables
//   o_mtime           : current mtime value
// A word write wins over a coincident increment of that word, and the carry
// into the other word is dropped for that cycle.
// -----------------------------------------------------------------------------
module clint_mh_timer
  import clint_mh_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_halt,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_be,
  output logic [63:0] o_mtime
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] r_count;
  logic [15:0] w_count_nxt;
  logic [63:0] r_mtime;
  logic [63:0] w_inc;
  logic [31:0] w_lo_nxt;
  logic [31:0] w_hi_nxt;
  logic        w_tick;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_tick      = !i_halt && (r_count == LAST);
    w_count_nxt = r_count;
    if (!i_halt) begin
      w_count_nxt = w_tick ? 16'd0 : r_count + 16'd1;
    end
    w_inc    = r_mtime + {63'd0, w_tick};
    w_lo_nxt = w_inc[31:0];
    w_hi_nxt = w_inc[63:32];
    if (i_wr_lo) begin
      w_lo_nxt = merge_bytes(r_mtime[31:0], i_wdata, i_be);
      w_hi_nxt = r_mtime[63:32];
    end else if (i_wr_hi) begin
      w_hi_nxt = merge_bytes(r_mtime[63:32], i_wdata, i_be);
      w_lo_nxt = r_mtime[31:0] + {31'd0, w_tick};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_mtime <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_mtime <= {w_hi_nxt, w_lo_nxt};
    end
  end

  assign o_mtime = r_mtime;

endmodule

// File: rtl/clint_mh.sv
// -----------------------------------------------------------------------------
// clint_mh
// Multi-hart core-local interruptor on the CPU data port. Claims
// BASE_ADDR..BASE_ADDR+0xBFFF and provides per-hart msip and mtimecmp plus a
// shared mtime.
//   clk, reset          : clock, asynchronous active-low reset
//   bus                 : data-port slave (addr/wdata/ren/wen/byte_select in,
//                         rdata/memReady out)
//   halt                : debug freeze of mtime
//   software_interrupt  : msip[h] bit 0, one bit per hart
//   timer_interrupt     : registered mtime >= mtimecmp[h], one bit per hart
// Access sequence: IDLE (capture) -> ACCESS (commit/read) -> DONE (data valid).
// -----------------------------------------------------------------------------
module clint_mh
  import clint_mh_pkg::*;
#(
  parameter int          NUM_HARTS = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  clint_mh_if.slave            bus,
  input  logic                 halt,
  output logic [NUM_HARTS-1:0] software_interrupt,
  output logic [NUM_HARTS-1:0] timer_interrupt
);

  state_e               r_state, w_state_nxt;
  logic [31:0]          w_offset;
  logic                 w_hit;
  logic [13:0]          r_woff;          // captured word offset within window
  logic [31:0]          r_wdata;
  logic [3:0]           r_be;
  logic                 r_wen;
  logic [31:0]          r_rdata;
  logic [31:0]          w_rdata_nxt;
  logic [NUM_HARTS-1:0] r_msip;
  logic [NUM_HARTS-1:0] r_tip;
  logic [63:0]          r_mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] w_msip_sel;
  logic [NUM_HARTS-1:0] w_cmp_sel;
  logic                 w_is_msip, w_is_cmp, w_is_mtime_lo, w_is_mtime_hi;
  logic                 w_commit;
  logic [63:0]          w_mtime;

  // Unsigned subtraction wraps addresses below BASE_ADDR to large values, so a
  // single compare covers both window edges.
  assign w_offset = bus.addr - BASE_ADDR;
  assign w_hit    = (bus.ren | bus.wen) && (w_offset < WINDOW_SIZE);

  assign w_is_msip     = {r_woff[13:12], 14'd0} == MSIP_OFF;
  assign w_is_cmp      = {r_woff[13:12], 14'd0} == MTIMECMP_OFF;
  assign w_is_mtime_lo = {r_woff, 2'b00} == MTIME_LO_OFF;
  assign w_is_mtime_hi = {r_woff, 2'b00} == MTIME_HI_OFF;
  assign w_commit      = (r_state == S_ACCESS) && r_wen;

  // Only implemented harts can match, so offsets for h >= NUM_HARTS fall
  // through to the read-zero / write-ignore default.
  always_comb begin
    w_msip_sel = '0;
    w_cmp_sel  = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      w_msip_sel[h] = w_is_msip && (r_woff[11:0] == 12'(h));
      w_cmp_sel[h]  = w_is_cmp  && (r_woff[11:1] == 11'(h));
    end
  end

  always_comb begin
    w_rdata_nxt = '0;
    if (w_is_mtime_lo) w_rdata_nxt = w_mtime[31:0];
    if (w_is_mtime_hi) w_rdata_nxt = w_mtime[63:32];
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (w_msip_sel[h]) w_rdata_nxt = {31'd0, r_msip[h]};
      if (w_cmp_sel[h])  w_rdata_nxt = r_woff[0] ? r_mtimecmp[h][63:32]
                                                 : r_mtimecmp[h][31:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_hit) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_woff  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_wen   <= 1'b0;
    end else if (r_state == S_IDLE && w_hit) begin
      r_woff  <= w_offset[15:2];
      r_wdata <= bus.wdata;
      r_be    <= bus.byte_select;
      r_wen   <= bus.wen;          // ren together with wen is a write
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (r_state == S_ACCESS && !r_wen) begin
      r_rdata <= w_rdata_nxt;
    end
  end

  // NOTE: the per-hart register arrays are built from resettable flops, not
  // RAM, because mtimecmp must come out of reset as all-ones so no timer
  // interrupt fires before software programs it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_msip <= '0;
      r_tip  <= '0;
      for (int h = 0; h < NUM_HARTS; h++) r_mtimecmp[h] <= '1;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (w_commit && w_msip_sel[h] && r_be[0]) r_msip[h] <= r_wdata[0];
        if (w_commit && w_cmp_sel[h]) begin
          if (r_woff[0])
            r_mtimecmp[h][63:32] <= merge_bytes(r_mtimecmp[h][63:32], r_wdata, r_be);
          else
            r_mtimecmp[h][31:0]  <= merge_bytes(r_mtimecmp[h][31:0], r_wdata, r_be);
        end
        r_tip[h] <= (w_mtime >= r_mtimecmp[h]);
      end
    end
  end

  clint_mh_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_halt  (halt),
    .i_wr_lo (w_commit && w_is_mtime_lo),
    .i_wr_hi (w_commit && w_is_mtime_hi),
    .i_wdata (r_wdata),
    .i_be    (r_be),
    .o_mtime (w_mtime)
  );

  assign bus.memReady        = (r_state != S_ACCESS);
  assign bus.rdata           = r_rdata;
  assign software_interrupt  = r_msip;
  assign timer_interrupt     = r_tip;

endmodule

// File: tb/tb_clint_mh.sv
// -----------------------------------------------------------------------------
// tb_clint_mh
// Two CLINT instances: dut0 (2 harts, PRESCALE=1) and dut1 (1 hart,
// PRESCALE=4). A reference mtime model runs alongside both; read expectations
// are queued when the access enters ACCESS and compared when memReady returns.
// -----------------------------------------------------------------------------
module tb_clint_mh;

  localparam logic [31:0] BASE = 32'h0200_0000;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       halt0 = 1'b0;
  logic       halt1 = 1'b0;
  logic [1:0] sw0, ti0;
  logic [0:0] sw1, ti1;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  exp_t sb[$];

  clint_mh_if bus0 ();
  clint_mh_if bus1 ();

  clint_mh #(.NUM_HARTS(2), .BASE_ADDR(BASE), .PRESCALE(1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .halt(halt0),
    .software_interrupt(sw0), .timer_interrupt(ti0));

  clint_mh #(.NUM_HARTS(1), .BASE_ADDR(BASE), .PRESCALE(4)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .halt(halt1),
    .software_interrupt(sw1), .timer_interrupt(ti1));

  always #5 clk = ~clk;

  // ---------------- reference mtime model (index 0 = dut0, 1 = dut1) -------
  logic [63:0] m_mtime [2];
  int unsigned m_cnt   [2];
  bit          m_wr    [2] = '{1'b0, 1'b0};
  bit          m_wr_hi [2] = '{1'b0, 1'b0};
  logic [31:0] m_wdata [2];

  function automatic int unsigned ps_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic bit halted(input int i);
    return (i == 0) ? halt0 : halt1;
  endfunction

  function automatic bit tick_of(input int i);
    return !halted(i) && (m_cnt[i] == ps_of(i) - 1);
  endfunction

  function automatic logic [63:0] mtime_next(input int i);
    logic [63:0] t;
    t = m_mtime[i];
    if (m_wr[i] && m_wr_hi[i]) return {m_wdata[i], t[31:0] + 32'(tick_of(i))};
    if (m_wr[i])               return {t[63:32], m_wdata[i]};
    return t + 64'(tick_of(i));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_mtime[i] <= '0;
        m_cnt[i]   <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_mtime[i] <= mtime_next(i);
        if (!halted(i)) m_cnt[i] <= tick_of(i) ? 0 : m_cnt[i] + 1;
      end
    end
  end

  // ---------------- helpers --------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_bus(input int sel, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic r, input logic w);
    bus0.addr = a;  bus0.wdata = d;  bus0.byte_select = be;
    bus1.addr = a;  bus1.wdata = d;  bus1.byte_select = be;
    bus0.ren = r && (sel == 0);  bus0.wen = w && (sel == 0);
    bus1.ren = r && (sel == 1);  bus1.wen = w && (sel == 1);
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? bus0.memReady : bus1.memReady;
  endfunction

  function automatic logic [31:0] rd(input int sel);
    return (sel == 0) ? bus0.rdata : bus1.rdata;
  endfunction

  // One complete access. Returns at the negedge of the DONE cycle.
  // Reads with use_model take their expectation from the model mtime in the
  // ACCESS cycle; otherwise exp_c is expected.
  task automatic bus_op(input int sel, input bit wr, input logic [15:0] off,
                        input logic [31:0] d, input logic [3:0] be, input string tag,
                        input bit use_model, input logic [31:0] exp_c);
    exp_t e;
    @(posedge clk); #1;
    set_bus(sel, BASE + {16'd0, off}, d, be, !wr, wr);
    @(posedge clk); #1;
    set_bus(sel, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    check({tag, " busy"}, rdy(sel), 1'b0);
    if (wr) begin
      if (off == 16'hBFF8 || off == 16'hBFFC) begin
        m_wr[sel]    = 1'b1;
        m_wr_hi[sel] = off[2];
        m_wdata[sel] = d;
      end
    end else begin
      e.tag = tag;
      e.exp = use_model ? (off[2] ? m_mtime[sel][63:32] : m_mtime[sel][31:0]) : exp_c;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    m_wr[sel] = 1'b0;
    @(negedge clk);
    check({tag, " ready"}, rdy(sel), 1'b1);
    if (!wr) begin
      e = sb.pop_front();
      check(e.tag, rd(sel), e.exp);
    end
  endtask

  task automatic wr0(input logic [15:0] off, input logic [31:0] d, input logic [3:0] be, input string tag);
    bus_op(0, 1'b1, off, d, be, tag, 1'b0, 32'd0);
  endtask

  task automatic rd_c(input int sel, input logic [15:0] off, input logic [31:0] exp, input string tag);
    bus_op(sel, 1'b0, off, 32'd0, 4'h0, tag, 1'b0, exp);
  endtask

  task automatic rd_m(input int sel, input logic [15:0] off, input string tag);
    bus_op(sel, 1'b0, off, 32'd0, 4'h0, tag, 1'b1, 32'd0);
  endtask

  // ---------------- directed sequence ---------------------------------------
  initial begin
    logic [63:0] target;
    logic [31:0] frozen;
    bit          found;

    set_bus(0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);

    // Reset state
    @(negedge clk);
    check("rst ready0", bus0.memReady, 1'b1);
    check("rst rdata0", bus0.rdata, 32'd0);
    check("rst sw0", sw0, 2'b00);
    check("rst ti0", ti0, 2'b00);
    check("rst ready1", bus1.memReady, 1'b1);
    check("rst sw1/ti1", {sw1, ti1}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b1;

    // mtime free-running with PRESCALE=1
    repeat (10) @(posedge clk);
    rd_m(0, 16'hBFF8, "mtime lo");
    rd_m(0, 16'hBFFC, "mtime hi");
    rd_c(0, 16'hBFFC, 32'd0, "mtime hi zero");

    // msip, including byte-lane gating and upper-bit masking
    wr0(16'h0004, 32'd1, 4'hF, "msip1 set");
    check("sw after set", sw0, 2'b10);
    wr0(16'h0004, 32'd0, 4'hF, "msip1 clr");
    check("sw after clr", sw0, 2'b00);
    wr0(16'h0004, 32'd1, 4'b0010, "msip1 lane");
    check("sw lane gated", sw0, 2'b00);
    rd_c(0, 16'h0004, 32'd0, "msip1 read");
    wr0(16'h0000, 32'hFFFF_FFFF, 4'hF, "msip0 set");
    check("sw msip0", sw0, 2'b01);
    rd_c(0, 16'h0000, 32'd1, "msip0 read");

    // mtimecmp[0]: high then low, interrupt exactly one cycle after match
    target = m_mtime[0] + 64'd40;
    wr0(16'h4004, target[63:32], 4'hF, "cmp0 hi");
    check("tip before lo", ti0, 2'b00);
    wr0(16'h4000, target[31:0], 4'hF, "cmp0 lo");
    rd_c(0, 16'h4000, target[31:0], "cmp0 lo read");
    rd_c(0, 16'h4004, target[63:32], "cmp0 hi read");
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (m_mtime[0] == target) found = 1'b1;
    end
    check("tip reach", found, 1'b1);
    check("tip match cycle", ti0, 2'b00);
    @(negedge clk);
    check("tip rise", ti0, 2'b01);
    wr0(16'h4000, 32'h0010_0000, 4'hF, "cmp0 move");
    check("tip lag", ti0, 2'b01);
    @(negedge clk);
    check("tip drop", ti0, 2'b00);

    // mtimecmp[1] byte lanes
    wr0(16'h4008, 32'h1122_3344, 4'hF, "cmp1 full");
    wr0(16'h4008, 32'hAABB_CCDD, 4'b0101, "cmp1 lanes");
    rd_c(0, 16'h4008, 32'h11BB_33DD, "cmp1 lanes read");
    rd_c(0, 16'h400C, 32'hFFFF_FFFF, "cmp1 hi read");

    // mtime writes, carry, coincident increment, wrap
    wr0(16'hBFFC, 32'd0, 4'hF, "mt hi0");
    wr0(16'hBFF8, 32'hFFFF_FFFF, 4'hF, "mt lo max");
    rd_m(0, 16'hBFF8, "carry lo");
    rd_c(0, 16'hBFFC, 32'd1, "carry hi");
    wr0(16'hBFF8, 32'h1234_5678, 4'hF, "mt lo wr");
    rd_m(0, 16'hBFF8, "lo wr value");
    rd_c(0, 16'hBFFC, 32'd1, "lo wr keeps hi");
    wr0(16'hBFFC, 32'h0000_000A, 4'hF, "mt hi wr");
    rd_c(0, 16'hBFFC, 32'h0000_000A, "hi wr value");
    rd_m(0, 16'hBFF8, "hi wr lo runs");
    wr0(16'hBFFC, 32'hFFFF_FFFF, 4'hF, "mt hi max");
    wr0(16'hBFF8, 32'hFFFF_FFFF, 4'hF, "mt lo max2");
    rd_c(0, 16'hBFFC, 32'd0, "wrap hi");
    rd_m(0, 16'hBFF8, "wrap lo");

    // Unimplemented harts / offsets and out-of-window requests
    rd_c(0, 16'h0008, 32'd0, "msip2 read");
    wr0(16'h0008, 32'd1, 4'hF, "msip2 wr");
    check("msip2 ignored", sw0, 2'b01);
    rd_c(0, 16'h0100, 32'd0, "off 0x100");
    wr0(16'h4010, 32'h5555_5555, 4'hF, "cmp2 wr");
    rd_c(0, 16'h4010, 32'd0, "cmp2 read");
    @(posedge clk); #1;
    set_bus(0, BASE + 32'h0000_C000, 32'd1, 4'hF, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_bus(0, BASE - 32'd4, 32'd0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("nohit above", bus0.memReady, 1'b1);
    @(posedge clk); #1;
    set_bus(0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("nohit below", bus0.memReady, 1'b1);

    // Prescaler and halt on dut1
    rd_m(1, 16'hBFF8, "ps lo");
    @(posedge clk); #1;
    halt1  = 1'b1;
    frozen = m_mtime[1][31:0];
    rd_c(1, 16'hBFF8, frozen, "halt frozen a");
    repeat (3) @(posedge clk);
    rd_c(1, 16'hBFF8, frozen, "halt frozen b");
    @(posedge clk); #1;
    halt1 = 1'b0;
    repeat (9) @(posedge clk);
    rd_m(1, 16'hBFF8, "ps resume");
    rd_m(1, 16'hBFFC, "ps hi");

    // Reset during ACCESS of an mtimecmp write
    @(posedge clk); #1;
    set_bus(0, BASE + 32'h0000_4000, 32'd0, 4'hF, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_bus(0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst mid busy", bus0.memReady, 1'b0);
    reset = 1'b0;
    #1;
    check("rst mid ready", bus0.memReady, 1'b1);
    check("rst mid rdata", bus0.rdata, 32'd0);
    check("rst mid sw", sw0, 2'b00);
    @(posedge clk); #1;
    reset = 1'b1;
    rd_c(0, 16'h4000, 32'hFFFF_FFFF, "cmp0 lo after rst");
    rd_c(0, 16'h4004, 32'hFFFF_FFFF, "cmp0 hi after rst");
    check("ti after rst", ti0, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clint_mh.md
Name: clint_mh

Overview:
- Parametrised multi-hart core-local interruptor (CLINT) on the CPU data port.
- Sits beside the data memory controller and claims a fixed address window.
- Provides a 64-bit mtime counter with prescaler and debug freeze.
- Provides per-hart msip and 64-bit mtimecmp registers, driving the CPU software_interrupt and timer_interrupt inputs.
- Handshakes through the same memReady convention as the memory controllers.

Parameters:
- NUM_HARTS, 1, number of harts/interrupt pairs (1..8).
- BASE_ADDR, 32'h0200_0000, window base; window is BASE_ADDR..BASE_ADDR+0xBFFF.
- PRESCALE, 1, clocks per mtime increment (1..65535).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- addr  in  32  byte address from CPU data port.
- wdata  in  32  write data.
- ren  in  1  read request.
- wen  in  1  write request.
- byte_select  in  4  byte lane enables for writes.
- halt  in  1  debug freeze; mtime and prescaler hold while 1.
- rdata  out  32  read data, valid when memReady=1 in DONE.
- memReady  out  1  1 = idle/complete, 0 = access in progress.
- software_interrupt  out  NUM_HARTS  msip[h] bit 0.
- timer_interrupt  out  NUM_HARTS  registered (mtime >= mtimecmp[h]), unsigned 64-bit.

Behaviour:
- Reset values (asynchronous, while reset=0):
  - mtime=0, prescaler count=0.
  - msip[*]=0, mtimecmp[*]=64'hFFFF_FFFF_FFFF_FFFF.
  - rdata=0, memReady=1, both interrupt vectors 0, FSM=IDLE.
- Hit = (ren|wen) & addr in window. ren and wen both set: treat as write. Non-hit requests are ignored; no state change.
- Register map (offset from BASE_ADDR, word-aligned; addr[1:0] ignored):
  - 0x0000+4h: msip[h]. Only bit 0 is stored; other bits read 0.
  - 0x4000+8h: mtimecmp[h] low word; +4 is the high word.
  - 0xBFF8: mtime low word; 0xBFFC: mtime high word.
  - h >= NUM_HARTS and all other offsets read 0; writes to them are ignored.
- Writes honour byte_select per byte lane. An msip write updates bit 0 only if byte_select[0]=1.
- FSM (IDLE, ACCESS, DONE):
  - IDLE: memReady=1. A hit captures addr/wdata/ren/wen/byte_select -> ACCESS.
  - ACCESS: memReady=0. Write committed at this edge, or read data registered into rdata -> DONE.
  - DONE: memReady=1, rdata valid; new requests ignored this cycle -> IDLE.
  - Access latency: 2 cycles from request to memReady-with-data. rdata holds its value until the next read completes.
- mtime:
  - Increments by 1 when prescaler count = PRESCALE-1 and halt=0; count then returns to 0.
  - Otherwise count increments while halt=0.
  - Wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0.
- CPU write to an mtime word in the same cycle as an increment: the written word takes the written value. Carry into the other word is suppressed that cycle. Prescaler count is unaffected.
- Half-word mtime/mtimecmp writes are not atomic; software writes the high word, then the low word.
- Interrupt outputs are registered. timer_interrupt[h] reflects the mtime/mtimecmp values from the previous cycle: 1-cycle lag after mtime reaches mtimecmp, and after an mtimecmp write. software_interrupt[h] goes high the cycle after ACCESS.
- Reset asserted mid-access: FSM returns to IDLE, the pending write is dropped, memReady=1.

Decomposition:
- Shared include clint_defs.vh:
  - Offsets MSIP_OFF, MTIMECMP_OFF, MTIME_LO_OFF, MTIME_HI_OFF.
  - FSM state encodings S_IDLE, S_ACCESS, S_DONE.
- Sub-module clint_timer: 64-bit mtime, prescaler, halt, word-write ports with suppressed carry.
- Decode, registers, FSM and compare stay in clint_mh.

Test Plan:
- Reset then read 0xBFF8/0xBFFC with PRESCALE=1, after 10 idle cycles -> mtime low ≈ 10, high 0. Each access: memReady low one cycle, high with data on the 2nd cycle.
- NUM_HARTS=2: write 0x1 to BASE+0x4 -> software_interrupt=2'b10 the cycle after ACCESS. Write 0x0 -> 2'b00. Write 0x1 with byte_select=4'b0010 -> unchanged.
- mtimecmp[0]=20 (high written first, then low) -> timer_interrupt[0] rises exactly one cycle after mtime==20. Rewrite mtimecmp[0]=1000 -> deasserts next cycle.
- PRESCALE=4, halt pulsed 3 cycles -> mtime advances once per 4 unhalted cycles; value is frozen during halt.
- mtime low written to 0xFFFF_FFFF with high=0, then run -> high becomes 1, low 0. Write mtime low coincident with an increment -> written value kept, high unchanged.
- Read BASE+0x8 with NUM_HARTS=2, and read BASE+0x100 -> 0. Assert reset during ACCESS of a mtimecmp write -> register stays all-ones, memReady=1.
